if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the MyProc2 pipeline; sits directly upstream of the decode stage and drives its IR_in/PC_in.
- Owns the word-addressed fetch PC and a single-outstanding req/ack instruction-memory port.
- Buffers returned words in a small FIFO and presents one instruction per cycle unless stalled.
- Handles taken-branch redirect (squash, including a late memory return) and stops fetching after a HALT.

Parameters:
- WIDTH, 32, datapath/instruction width; PC is WIDTH-2 bits (word address).
- BUF_DEPTH, 2, instruction FIFO entries (power of two, ≥2).
- RESET_PC, 0, fetch PC after reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- IR_out  output  WIDTH  instruction to decode.
- PC_out  output  WIDTH-2  word PC of IR_out.
- Mem_add  output  WIDTH-2  fetch word address.
- Mem_req  output  1  request valid; held with stable Mem_add until ack.
- Mem_ack  input  1  one-cycle acknowledge; Mem_data valid in that cycle.
- Mem_data  input  WIDTH  returned instruction word.
- IsStall  input  1  downstream stall; hold IR_out/PC_out.
- Br_taken  input  1  one-cycle redirect strobe from execute.
- Br_tgt  input  WIDTH-2  redirect word address.

Behaviour:
- Reset (async, rst_n low):
  - IR_out = `NOP, PC_out = 0, Mem_req = 0, Mem_add = RESET_PC.
  - Fetch_PC = RESET_PC, FIFO empty, state FETCH.
- FSM states:
  - FETCH: normal operation.
  - DISCARD: awaiting ack of a squashed request.
  - HALTED: no further requests.
- Request issue (FETCH only):
  - Mem_req rises at a clock edge when no request is outstanding and FIFO count + 0 < BUF_DEPTH.
  - Mem_add = Fetch_PC.
  - At most one request outstanding.
- Ack in FETCH:
  - {Fetch_PC, Mem_data} pushed into FIFO; Fetch_PC += 1 (wraps modulo 2^(WIDTH-2)).
  - Mem_req may stay high at the same edge with the new address if the FIFO will still have space after the push (back-to-back fetch).
  - If Mem_data[31:26] == `HALT: push it, then go to HALTED; Mem_req drops.
- Output register (every edge, unless a redirect overrides):
  - IsStall=1: IR_out/PC_out hold; FIFO may still fill until full.
  - IsStall=0 and FIFO non-empty: pop head into IR_out/PC_out.
  - IsStall=0 and FIFO empty: IR_out = `NOP (bubble); PC_out holds.
  - No bypass: an acked word reaches IR_out no earlier than the edge after the ack edge.
  - Minimum latency is req edge → ack edge (+1) → IR_out edge (+2).
- Redirect (Br_taken=1 at an edge); highest priority, overrides IsStall:
  - FIFO cleared, IR_out = `NOP, Fetch_PC = Br_tgt.
  - Request outstanding and Mem_ack=0 → DISCARD. Mem_req stays high with the old address until ack. The acked data is dropped. Next edge after the ack issues Br_tgt, state FETCH.
  - Mem_ack=1 in the same cycle → data dropped, FETCH, Br_tgt request issued at that edge.
  - Br_taken in HALTED → FETCH at Br_tgt.
  - Br_taken in DISCARD → Fetch_PC updated to the newest Br_tgt; remain DISCARD.
- Full FIFO: no new request. A push and a pop in the same cycle are both allowed, count unchanged.
- Mem_ack with no request outstanding is ignored (the bench must flag it).
- Reset mid-request: the outstanding request is abandoned; an ack arriving after reset release with Mem_req low is ignored.

Decomposition:
- Shared package/include, extending params.v/ISA.v:
  - `WIDTH and `NOP (existing).
  - `HALT opcode (existing).
  - Fetch-state encodings IF_FETCH/IF_DISCARD/IF_HALTED.
  - `RESET_PC.
- One sub-module: if_fifo.
  - Parameterised DEPTH×(WIDTH+WIDTH-2), synchronous push/pop/clear, async active-low reset.
  - Outputs count, full, empty.
- FSM, Fetch_PC and output register live in if_stage.

Test Plan:
- Reset then ack every request one cycle later, memory word k = 0x0400_0000|k: Mem_add 0,1,2…; IR_out `NOP for 2 cycles, then words 0,1,2… on consecutive cycles with PC_out 0,1,2.
- IsStall high for 4 cycles mid-stream: IR_out/PC_out frozen; at most BUF_DEPTH=2 requests acked, Mem_req low while full; on release the next two buffered words appear with no gap and no loss.
- Br_taken with Br_tgt=0x100 while request to 0x5 is outstanding, ack 3 cycles later with 0xDEAD_BEEF: word dropped, IR_out `NOP, next Mem_add=0x100, PC_out sequence resumes at 0x100.
- Br_taken and Mem_ack in the same cycle (Br_tgt=0x40): acked word never appears; Mem_req high at 0x40 at that edge.
- Word at PC 0x7 has opcode `HALT: IR_out delivers PC 0x7 HALT, then `NOP forever, Mem_req stays 0; Br_taken to 0x0 restarts fetch at 0.
- rst_n pulsed low asynchronously mid-request: all outputs immediately at reset values; a late Mem_ack is ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared definitions for the instruction-fetch stage.
//   DEF_WIDTH / DEF_BUF_DEPTH / DEF_RESET_PC : default parameter values
//   NOP      : instruction word injected as a pipeline bubble
//   HALT_OP  : opcode (bits [31:26]) that stops fetching
//   if_state_e : fetch FSM state encodings
package if_stage_pkg;

  localparam int          DEF_WIDTH     = 32;
  localparam int          DEF_BUF_DEPTH = 2;
  localparam int unsigned DEF_RESET_PC  = 0;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [5:0]  HALT_OP = 6'h3F;

  typedef enum logic [1:0] {
    IF_FETCH   = 2'd0,
    IF_DISCARD = 2'd1,
    IF_HALTED  = 2'd2
  } if_state_e;

  function automatic logic is_halt(input logic [5:0] opcode);
    return opcode == HALT_OP;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// if_fifo: small instruction buffer, DEPTH entries of DW bits.
//   i_push / i_data : write one entry (accepted when not full, or when
//                     a pop happens in the same cycle)
//   i_pop           : drop the head entry (ignored when empty)
//   i_clr           : synchronous flush, wins over push/pop
//   o_data          : head entry (valid when !o_empty)
//   o_count / o_full / o_empty : occupancy
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int DW    = 62
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [DW-1:0]           i_data,
  input  logic                    i_pop,
  input  logic                    i_clr,
  output logic [DW-1:0]           o_data,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_count == (AW+1)'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !w_empty;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage feeding decode.
//   clk, rst_n          : clock, async active-low reset
//   IR_out / PC_out     : registered instruction and its word PC to decode
//   Mem_add / Mem_req   : fetch request (held stable until Mem_ack)
//   Mem_ack / Mem_data  : one-cycle acknowledge with instruction word
//   IsStall             : hold IR_out/PC_out
//   Br_taken / Br_tgt   : redirect strobe and word target
//
// state      | meaning
// IF_FETCH   | normal fetching into the buffer
// IF_DISCARD | waiting for the ack of a squashed request, data dropped
// IF_HALTED  | HALT fetched, no further requests until a redirect
module if_stage
  import if_stage_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int          BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned RESET_PC  = DEF_RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [WIDTH-1:0]   IR_out,
  output logic [WIDTH-3:0]   PC_out,
  output logic [WIDTH-3:0]   Mem_add,
  output logic               Mem_req,
  input  logic               Mem_ack,
  input  logic [WIDTH-1:0]   Mem_data,
  input  logic               IsStall,
  input  logic               Br_taken,
  input  logic [WIDTH-3:0]   Br_tgt
);

  localparam int                PC_W   = WIDTH - 2;
  localparam int                DW     = WIDTH + PC_W;
  localparam int                CW     = $clog2(BUF_DEPTH) + 1;
  localparam logic [PC_W-1:0]   L_RPC  = PC_W'(RESET_PC);
  localparam logic [WIDTH-1:0]  L_NOP  = WIDTH'(NOP);

  if_state_e        r_state;
  logic [PC_W-1:0]  r_fetch_pc;
  logic             r_mem_req;
  logic [PC_W-1:0]  r_mem_add;
  logic [WIDTH-1:0] r_ir;
  logic [PC_W-1:0]  r_pc;

  logic             w_ack;
  logic             w_halt_word;
  logic             w_push;
  logic             w_pop;
  logic [DW-1:0]    w_fifo_din;
  logic [DW-1:0]    w_fifo_dout;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_cnt_after;
  logic             w_full;
  logic             w_empty;
  logic [PC_W-1:0]  w_pc_inc;

  assign w_ack       = r_mem_req && Mem_ack;
  assign w_halt_word = is_halt(Mem_data[WIDTH-1 -: 6]);
  assign w_push      = (r_state == IF_FETCH) && w_ack && !Br_taken;
  assign w_pop       = !IsStall && !w_empty && !Br_taken;
  assign w_fifo_din  = {r_fetch_pc, Mem_data};
  assign w_pc_inc    = r_fetch_pc + PC_W'(1);
  // Occupancy once this edge's push and pop have both landed.
  assign w_cnt_after = w_count + CW'(w_push) - CW'(w_pop);

  if_fifo #(
    .DEPTH (BUF_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_fifo_din),
    .i_pop   (w_pop),
    .i_clr   (Br_taken),
    .o_data  (w_fifo_dout),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IF_FETCH;
      r_fetch_pc <= L_RPC;
      r_mem_req  <= 1'b0;
      r_mem_add  <= L_RPC;
    end else if (Br_taken) begin
      r_fetch_pc <= Br_tgt;
      if (r_mem_req && !Mem_ack) begin
        // Request still in flight: keep it on the bus and squash its data.
        r_state <= IF_DISCARD;
      end else if (r_state == IF_DISCARD) begin
        // Squashed ack lands together with a newer redirect.
        r_state   <= IF_FETCH;
        r_mem_req <= 1'b0;
        r_mem_add <= Br_tgt;
      end else begin
        r_state   <= IF_FETCH;
        r_mem_req <= 1'b1;
        r_mem_add <= Br_tgt;
      end
    end else begin
      case (r_state)
        IF_FETCH: begin
          if (w_ack) begin
            r_fetch_pc <= w_pc_inc;
            r_mem_add  <= w_pc_inc;
            if (w_halt_word) begin
              r_state   <= IF_HALTED;
              r_mem_req <= 1'b0;
            end else begin
              r_mem_req <= (w_cnt_after < CW'(BUF_DEPTH));
            end
          end else if (!r_mem_req && !w_full) begin
            r_mem_req <= 1'b1;
            r_mem_add <= r_fetch_pc;
          end
        end
        IF_DISCARD: begin
          if (w_ack) begin
            r_state   <= IF_FETCH;
            r_mem_req <= 1'b0;
            r_mem_add <= r_fetch_pc;
          end
        end
        IF_HALTED: begin
          r_mem_req <= 1'b0;
        end
        default: begin
          r_state   <= IF_FETCH;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= L_NOP;
      r_pc <= '0;
    end else if (Br_taken) begin
      r_ir <= L_NOP;
    end else if (!IsStall) begin
      if (!w_empty) begin
        r_ir <= w_fifo_dout[WIDTH-1:0];
        r_pc <= w_fifo_dout[DW-1:WIDTH];
      end else begin
        r_ir <= L_NOP;
      end
    end
  end

  assign IR_out  = r_ir;
  assign PC_out  = r_pc;
  assign Mem_req = r_mem_req;
  assign Mem_add = r_mem_add;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] IR_out;
  logic [29:0] PC_out;
  logic [29:0] Mem_add;
  logic        Mem_req;
  logic        Mem_ack = 1'b0;
  logic [31:0] Mem_data = '0;
  logic        IsStall = 1'b0;
  logic        Br_taken = 1'b0;
  logic [29:0] Br_tgt = '0;

  int total = 0;
  int bad   = 0;

  logic hold, fdata_en, force_spur, halt_mode, discard;
  logic [61:0] sb_q[$];

  always #5 clk = ~clk;

  if_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .IR_out   (IR_out),
    .PC_out   (PC_out),
    .Mem_add  (Mem_add),
    .Mem_req  (Mem_req),
    .Mem_ack  (Mem_ack),
    .Mem_data (Mem_data),
    .IsStall  (IsStall),
    .Br_taken (Br_taken),
    .Br_tgt   (Br_tgt)
  );

  typedef struct {
    logic        stall;
    logic [31:0] ir;
    logic [29:0] pc;
    logic        req;
    logic [29:0] add;
  } vec_t;

  vec_t tbl[17];

  function automatic logic [31:0] w(input logic [29:0] a);
    return 32'h0400_0000 | {2'b00, a};
  endfunction

  function automatic vec_t v(input logic s, input logic [31:0] ir, input logic [29:0] pc,
                             input logic req, input logic [29:0] add);
    vec_t r;
    r.stall = s; r.ir = ir; r.pc = pc; r.req = req; r.add = add;
    return r;
  endfunction

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (halt_mode && a == 30'd7) return {HALT_OP, 26'd7};
    return w(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory model: answers the request visible on the bus at the next edge.
  // Words acked alongside or after a redirect are never expected at decode.
  task automatic mem_drive();
    Mem_ack = 1'b0;
    if (Br_taken) sb_q.delete();
    if (force_spur) begin
      Mem_ack  = 1'b1;
      Mem_data = 32'hBAD0_0001;
    end else if (Mem_req && !hold) begin
      Mem_ack  = 1'b1;
      Mem_data = fdata_en ? 32'hDEAD_BEEF : mem_word(Mem_add);
      if (Br_taken || discard) discard = 1'b0;
      else sb_q.push_back({Mem_add, Mem_data});
    end else if (Br_taken && Mem_req) begin
      discard = 1'b1;
    end
  endtask

  task automatic sb_check();
    logic [61:0] e;
    if (rst_n && !IsStall && !Br_taken && IR_out != NOP) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got ir=%h pc=%h want no word", IR_out, PC_out);
      end else begin
        e = sb_q.pop_front();
        chk("sb_ir", IR_out, e[31:0]);
        chk("sb_pc", {2'b00, PC_out}, {2'b00, e[61:32]});
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mem_drive();
    @(posedge clk);
    #1;
    sb_check();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    IsStall = 1'b0; Br_taken = 1'b0; Br_tgt = '0;
    hold = 1'b0; fdata_en = 1'b0; force_spur = 1'b0; halt_mode = 1'b0; discard = 1'b0;
    Mem_ack = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string nm, input logic [31:0] ir, input logic req, input logic [29:0] add);
    chk({nm, "_ir"}, IR_out, ir);
    chk({nm, "_req"}, {31'd0, Mem_req}, {31'd0, req});
    chk({nm, "_add"}, {2'b00, Mem_add}, {2'b00, add});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;

    tbl[0] = v(0, NOP, 30'd0, 1, 30'd0);
    tbl[1] = v(0, NOP, 30'd0, 1, 30'd1);
    for (int k = 2; k < 8; k++) tbl[k] = v(0, w(30'(k - 2)), 30'(k - 2), 1, 30'(k));
    for (int k = 8; k < 12; k++) tbl[k] = v(1, w(30'd5), 30'd5, 0, 30'd8);
    tbl[12] = v(0, w(30'd6), 30'd6, 0, 30'd8);
    tbl[13] = v(0, w(30'd7), 30'd7, 1, 30'd8);
    tbl[14] = v(0, NOP,      30'd7, 1, 30'd9);
    tbl[15] = v(0, w(30'd8), 30'd8, 1, 30'd10);
    tbl[16] = v(0, w(30'd9), 30'd9, 1, 30'd11);

    // Reset values while rst_n is low.
    hold = 1'b0; fdata_en = 1'b0; force_spur = 1'b0; halt_mode = 1'b0; discard = 1'b0;
    #1;
    chk_out("rst", NOP, 1'b0, 30'd0);
    chk("rst_pc", {2'b00, PC_out}, 32'd0);

    // Streaming with a mid-stream stall.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      IsStall = tbl[i].stall;
      step();
      chk_out($sformatf("tbl%0d", i), tbl[i].ir, tbl[i].req, tbl[i].add);
      chk($sformatf("tbl%0d_pc", i), {2'b00, PC_out}, {2'b00, tbl[i].pc});
    end
    IsStall = 1'b0;

    // Redirect with a request outstanding; squashed ack 3 cycles later.
    do_reset();
    repeat (6) step();
    chk_out("pre_br", w(30'd3), 1'b1, 30'd5);
    hold = 1'b1; Br_taken = 1'b1; Br_tgt = 30'h100;
    step();
    Br_taken = 1'b0;
    chk_out("br_e7", NOP, 1'b1, 30'd5);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_out("br_wait", NOP, 1'b1, 30'd5);
    end
    hold = 1'b0; fdata_en = 1'b1;
    step();
    fdata_en = 1'b0;
    chk("br_ackdrop_req", {31'd0, Mem_req}, 32'd0);
    chk("br_ackdrop_ir", IR_out, NOP);
    step();
    chk_out("br_issue", NOP, 1'b1, 30'h100);
    step();
    chk_out("br_e12", NOP, 1'b1, 30'h101);
    step();
    chk_out("br_e13", w(30'h100), 1'b1, 30'h102);
    chk("br_e13_pc", {2'b00, PC_out}, 32'h100);

    // Redirect coinciding with an ack.
    Br_taken = 1'b1; Br_tgt = 30'h40;
    step();
    Br_taken = 1'b0;
    chk_out("brack_e14", NOP, 1'b1, 30'h40);
    step();
    chk_out("brack_e15", NOP, 1'b1, 30'h41);
    step();
    chk_out("brack_e16", w(30'h40), 1'b1, 30'h42);
    chk("brack_e16_pc", {2'b00, PC_out}, 32'h40);

    // HALT at PC 7, then restart by redirect.
    do_reset();
    halt_mode = 1'b1;
    repeat (9) step();
    chk("halt_req_drop", {31'd0, Mem_req}, 32'd0);
    step();
    chk("halt_ir", IR_out, {HALT_OP, 26'd7});
    chk("halt_pc", {2'b00, PC_out}, 32'd7);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halted_ir", IR_out, NOP);
      chk("halted_req", {31'd0, Mem_req}, 32'd0);
      chk("halted_pc", {2'b00, PC_out}, 32'd7);
    end
    Br_taken = 1'b1; Br_tgt = 30'd0;
    step();
    Br_taken = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      step();
      if (IR_out != NOP) found = 1'b1;
    end
    chk("restart_seen", {31'd0, found}, 32'd1);
    chk("restart_ir", IR_out, w(30'd0));
    chk("restart_pc", {2'b00, PC_out}, 32'd0);

    // Async reset mid-request, then a stray ack after release.
    hold = 1'b1;
    step();
    step();
    chk("midreq_req", {31'd0, Mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", NOP, 1'b0, 30'd0);
    chk("async_rst_pc", {2'b00, PC_out}, 32'd0);
    sb_q.delete();
    hold = 1'b0; discard = 1'b0; halt_mode = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_spur = 1'b1;
    step();
    force_spur = 1'b0;
    chk_out("post_e1", NOP, 1'b1, 30'd0);
    step();
    chk_out("post_e2", NOP, 1'b1, 30'd1);
    step();
    chk_out("post_e3", w(30'd0), 1'b1, 30'd2);
    chk("post_e3_pc", {2'b00, PC_out}, 32'd0);
    step();
    chk_out("post_e4", w(30'd1), 1'b1, 30'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
